// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD driver.
// Holds the FSM state encoding, panel command bytes and init sequence length.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPowerup,
        StLoad,
        StSetup,
        StEnHi,
        StWait,
        StIdle
    } lcd_state_e;

    localparam logic [7:0] FUNC_SET_8B = 8'h38;
    localparam logic [7:0] DISP_ON     = 8'h0C;
    localparam logic [7:0] CLEAR       = 8'h01;
    localparam logic [7:0] HOME        = 8'h02;
    localparam logic [7:0] ENTRY_INC   = 8'h06;

    localparam int unsigned INIT_LEN = 7;

    // Clear and home are the only commands needing the long post-pulse wait.
    function automatic logic is_long_cmd(logic rs, logic [7:0] data);
        return !rs && (data == CLEAR || data == HOME);
    endfunction

endpackage

// File: rtl/lcd_hd44780_driver_if.sv
// Upstream byte handshake into the LCD driver: one byte per valid/ready transfer.
// rs selects command (0) or character data (1).
interface lcd_hd44780_driver_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (output in_valid, output in_rs, output in_data, input in_ready);
    modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_init_rom.sv
// Power-up command sequence for the panel in 8-bit mode, indexed by init step.
// Purely combinational; out-of-range indices return 8'h00.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [2:0] index,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        case (index)
            3'd0, 3'd1, 3'd2, 3'd3: data = FUNC_SET_8B;
            3'd4:                   data = DISP_ON;
            3'd5:                   data = CLEAR;
            3'd6:                   data = ENTRY_INC;
            default:                data = 8'h00;
        endcase
    end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit bus driver: runs the power-up init, then writes one byte per handshake
// with a fully timed setup / EN pulse / busy-wait cycle. All outputs are registered.
module lcd_hd44780_driver
    import lcd_pkg::*;
#(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EN_HIGH_CYC = 25,
    parameter int unsigned CMD_WAIT    = 2500,
    parameter int unsigned CLEAR_WAIT  = 82000
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_hd44780_driver_if.slave  up,
    output logic                 init_done,
    output logic                 busy,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_EN,
    output logic [7:0]           LCD_D
);

    localparam logic [CNT_W-1:0] PowerupLast = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] SetupLast   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EnHighLast  = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CmdLast     = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] ClearLast   = CNT_W'(CLEAR_WAIT - 1);
    localparam logic [2:0]       InitLast    = 3'(INIT_LEN - 1);

    lcd_state_e       state;
    logic [CNT_W-1:0] count;
    logic [2:0]       init_idx;
    logic [7:0]       rom_data;
    logic             ready;
    logic             wait_last;

    assign LCD_RW      = 1'b0;
    assign up.in_ready = ready;

    lcd_init_rom u_init_rom (
        .index (init_idx),
        .data  (rom_data)
    );

    // Wait length follows the byte currently latched on the bus.
    assign wait_last = is_long_cmd(LCD_RS, LCD_D) ? (count == ClearLast) : (count == CmdLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StPowerup;
            count     <= '0;
            init_idx  <= '0;
            LCD_EN    <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_D     <= 8'h00;
            ready     <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            unique case (state)
                StPowerup: begin
                    if (count == PowerupLast) begin
                        state <= StLoad;
                        count <= '0;
                    end
                end
                StLoad: begin
                    LCD_RS <= 1'b0;
                    LCD_D  <= rom_data;
                    state  <= StSetup;
                    count  <= '0;
                end
                StSetup: begin
                    if (count == SetupLast) begin
                        LCD_EN <= 1'b1;
                        state  <= StEnHi;
                        count  <= '0;
                    end
                end
                StEnHi: begin
                    if (count == EnHighLast) begin
                        LCD_EN <= 1'b0;
                        state  <= StWait;
                        count  <= '0;
                    end
                end
                StWait: begin
                    if (wait_last) begin
                        count <= '0;
                        if (init_done || init_idx == InitLast) begin
                            init_done <= 1'b1;
                            ready     <= 1'b1;
                            busy      <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                            state    <= StLoad;
                        end
                    end
                end
                StIdle: begin
                    count <= '0;
                    if (up.in_valid) begin
                        LCD_RS <= up.in_rs;
                        LCD_D  <= up.in_data;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= StSetup;
                    end
                end
                default: begin
                    state <= StPowerup;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Scoreboard bench for the HD44780 driver: stimulus queues expected panel writes,
// a negedge monitor checks every EN pulse, its timing and the gaps between pulses.
module tb_lcd_hd44780_driver;

    localparam int PU = 100;
    localparam int SU = 2;
    localparam int EH = 4;
    localparam int CW = 10;
    localparam int LW = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_done, busy, LCD_RS, LCD_RW, LCD_EN;
    logic [7:0] LCD_D;

    lcd_hd44780_driver_if bus ();

    lcd_hd44780_driver #(
        .CNT_W       (20),
        .POWERUP_CYC (PU),
        .SETUP_CYC   (SU),
        .EN_HIGH_CYC (EH),
        .CMD_WAIT    (CW),
        .CLEAR_WAIT  (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up        (bus),
        .init_done (init_done),
        .busy      (busy),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_D     (LCD_D)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // to_rise: the following pulse comes straight from the init sequence, so the low gap
    // runs to the next EN rise; otherwise it runs until the driver is ready again.
    typedef struct {
        bit       rs;
        bit [7:0] d;
        bit       to_rise;
        int       gap;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int wait_for(bit rs, bit [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? LW : CW;
    endfunction

    task automatic push(bit rs, bit [7:0] d, bit to_rise);
        exp_t e;
        e.rs      = rs;
        e.d       = d;
        e.to_rise = to_rise;
        e.gap     = to_rise ? wait_for(rs, d) + 1 + SU : wait_for(rs, d);
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        bit [7:0] seq [7];
        seq = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 7; i++) push(1'b0, seq[i], i < 6);
    endtask

    // Monitor state
    exp_t cur;
    bit   have_cur, in_gap, en_prev, acc_pend, first_pend, d_ok;
    int   hi_cnt, lo_cnt, acc_cyc, rel_cyc;

    always @(negedge clk) begin
        if (reset) begin
            have_cur = 0;
            in_gap   = 0;
            en_prev  = 0;
            acc_pend = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_pend = 1;
                acc_cyc  = cyc;
                chk("accept_after_init", int'(init_done), 1);
            end
            if (LCD_EN && !en_prev) begin
                if (in_gap && have_cur && cur.to_rise) chk("gap_to_next_pulse", lo_cnt + 1, cur.gap);
                in_gap = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: rs=%0d d=0x%0h at cycle %0d", LCD_RS, LCD_D, cyc);
                    have_cur = 0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1;
                    chk("pulse_rs", int'(LCD_RS), int'(cur.rs));
                    chk("pulse_data", int'(LCD_D), int'(cur.d));
                    chk("pulse_rw", int'(LCD_RW), 0);
                end
                if (first_pend) begin
                    chk("powerup_to_first_en", cyc - rel_cyc, PU + 1 + SU);
                    first_pend = 0;
                end else if (acc_pend) begin
                    chk("accept_to_en_rise", cyc - acc_cyc, SU + 1);
                    acc_pend = 0;
                end
                hi_cnt = 1;
                d_ok   = 1;
            end else if (LCD_EN && en_prev) begin
                hi_cnt++;
                if (have_cur && (LCD_D != cur.d || LCD_RS != cur.rs)) d_ok = 0;
            end else if (!LCD_EN && en_prev) begin
                chk("en_high_cycles", hi_cnt, EH);
                chk("bus_stable_during_en", int'(d_ok), 1);
                in_gap = have_cur;
                lo_cnt = 0;
            end else if (in_gap) begin
                lo_cnt++;
                if (!cur.to_rise && bus.in_ready) begin
                    chk("wait_to_ready", lo_cnt, cur.gap);
                    in_gap = 0;
                end else if (lo_cnt > 500) begin
                    total++;
                    bad++;
                    $display("FAIL gap_timeout: no follow-up after pulse d=0x%0h", cur.d);
                    in_gap = 0;
                end
            end
            en_prev = LCD_EN;
        end
    end

    task automatic check_reset_vals();
        chk("rst_en", int'(LCD_EN), 0);
        chk("rst_rs", int'(LCD_RS), 0);
        chk("rst_rw", int'(LCD_RW), 0);
        chk("rst_d", int'(LCD_D), 0);
        chk("rst_ready", int'(bus.in_ready), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_busy", int'(busy), 1);
    endtask

    task automatic release_reset();
        reset      = 1'b0;
        rel_cyc    = cyc;
        first_pend = 1;
        push_init();
    endtask

    // Present a byte and return #1 after the edge that accepts it; valid stays high.
    task automatic send(bit rs, bit [7:0] d, output int acc_at);
        int n;
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = d;
        push(rs, d, 1'b0);
        n = 0;
        acc_at = -1;
        while (acc_at < 0 && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                acc_at = cyc;
            end
        end
        if (acc_at < 0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", d);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_ready(string name, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 3000);
        at = cyc;
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: in_ready never returned", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t_acc, t_rdy, n;
        bit [7:0] cmds [3];
        bit [7:0] led  [5];
        cmds = '{8'h01, 8'h02, 8'h80};
        led  = '{8'h4C, 8'h45, 8'h44, 8'h20, 8'h31};

        bus.in_valid = 1'b0;
        bus.in_rs    = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();

        // Init with a byte already pending: it must wait until init completes.
        release_reset();
        send(1'b1, 8'h41, t_acc);
        chk("init_done_at_first_accept", int'(init_done), 1);
        bus.in_valid = 1'b0;
        wait_ready("after_41", t_rdy);

        send(1'b1, 8'h4C, t_acc);
        bus.in_valid = 1'b0;
        wait_ready("after_4c", t_rdy);
        chk("ready_latency_char", t_rdy - t_acc, SU + EH + CW);

        for (int i = 0; i < 3; i++) begin
            send(1'b0, cmds[i], t_acc);
            bus.in_valid = 1'b0;
            wait_ready("after_cmd", t_rdy);
            chk("ready_latency_cmd", t_rdy - t_acc, SU + EH + wait_for(1'b0, cmds[i]));
        end

        for (int i = 0; i < 5; i++) send(1'b1, led[i], t_acc);
        bus.in_valid = 1'b0;
        wait_ready("after_stream", t_rdy);

        for (int i = 0; i < 20; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom), t_acc);
            if ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                wait_ready("after_random", t_rdy);
            end
        end
        bus.in_valid = 1'b0;
        wait_ready("after_random_tail", t_rdy);
        chk("queue_drained_before_reset", exp_q.size(), 0);

        // Reset in the middle of an EN pulse.
        send(1'b0, 8'h80, t_acc);
        bus.in_valid = 1'b0;
        n = 0;
        while (!LCD_EN && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("en_seen_before_reset", int'(LCD_EN), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("en_drops_on_reset", int'(LCD_EN), 0);
        check_reset_vals();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        wait_ready("reinit", t_rdy);
        chk("reinit_done", int'(init_done), 1);
        send(1'b1, 8'h5A, t_acc);
        bus.in_valid = 1'b0;
        wait_ready("after_5a", t_rdy);
        chk("queue_drained_at_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
